btn_up_pulse: RTL

//   Upstream stage for the two-digit base-3 counter: turns a raw, bouncing

---
 rtl/btn_up_pulse_if.sv | 27 ++
 rtl/btn_up_pulse.sv | 122 ++++++++++++
 2 files changed

// File: rtl/btn_up_pulse_if.sv
// Button front-end bus: raw button and repeat enable in, step pulse and
// debounced level out.
//   btn_raw    raw button, active-high, asynchronous to clk, may bounce
//   rpt_en     auto-repeat enable while held, synchronous to clk
//   up         one-cycle step pulse toward the counter
//   btn_level  debounced button level
// master drives the button side; slave is the pulse generator.
interface btn_up_pulse_if;
  logic btn_raw;
  logic rpt_en;
  logic up;
  logic btn_level;

  modport master (
    output btn_raw,
    output rpt_en,
    input  up,
    input  btn_level
  );

  modport slave (
    input  btn_raw,
    input  rpt_en,
    output up,
    output btn_level
  );
endinterface

// File: rtl/btn_up_pulse.sv
// Push-button front end for the two-digit base-3 counter. Synchronises and
// debounces a raw button, emits one registered `up` pulse per press and,
// with rpt_en set, auto-repeat pulses while the button stays held.
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    btn_up_pulse_if.slave: btn_raw, rpt_en in; up, btn_level out
module btn_up_pulse #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned REPEAT_DLY = 16,
  parameter int unsigned REPEAT_PER = 8,
  parameter int unsigned CNT_W      = 8
) (
  input logic           clk,
  input logic           n_rst,
  btn_up_pulse_if.slave bus
);

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DlyLast = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PerLast = CNT_W'(REPEAT_PER - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StHold, StRpt} state_e;

  logic [1:0]       sync_q;
  logic             btn_s;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] rt_q, rt_d;
  logic             up_q, up_d;
  state_e           state_q, state_d;
  logic             rise, fall;

  assign btn_s = sync_q[1];

  // Debounce: level only follows btn_s after DEB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    if (btn_s != level_q) begin
      if (deb_cnt_q == DebLast) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CntOne;
      end
    end
  end

  // Edges of the next level value, so the press pulse registers alongside btn_level.
  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_comb begin
    state_d = state_q;
    rt_d    = rt_q;
    up_d    = 1'b0;
    if (fall) begin
      // Release beats any repeat falling due in the same cycle.
      state_d = StIdle;
      rt_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            up_d    = 1'b1;
            rt_d    = '0;
            state_d = StHold;
          end
        end
        StHold: begin
          if (!bus.rpt_en) begin
            rt_d = '0;
          end else if (rt_q == DlyLast) begin
            up_d    = 1'b1;
            rt_d    = '0;
            state_d = StRpt;
          end else begin
            rt_d = rt_q + CntOne;
          end
        end
        StRpt: begin
          // Dropping rpt_en falls back to HOLD so re-enabling waits the full delay.
          if (!bus.rpt_en) begin
            rt_d    = '0;
            state_d = StHold;
          end else if (rt_q == PerLast) begin
            up_d = 1'b1;
            rt_d = '0;
          end else begin
            rt_d = rt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          rt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q    <= '0;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      rt_q      <= '0;
      up_q      <= 1'b0;
      state_q   <= StIdle;
    end else begin
      sync_q    <= {sync_q[0], bus.btn_raw};
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      rt_q      <= rt_d;
      up_q      <= up_d;
      state_q   <= state_d;
    end
  end

  assign bus.up        = up_q;
  assign bus.btn_level = level_q;

endmodule
